comunicaciones_rx: RTL and testbench

//  Receive side of the Comunicaciones serial link: 8N1 asynchronous receiver with RX FIFO, memory-mapped on the J1 I/O bus.

---
 rtl/comunicaciones_pkg.sv | 28 ++
 rtl/comunicaciones_rx_uart_rx_core.sv | 116 +++++++++++
 rtl/comunicaciones_rx.sv | 110 +++++++++++
 tb/tb_comunicaciones_rx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/comunicaciones_pkg.sv
// rtl/comunicaciones_pkg.sv - shared constants for the Comunicaciones link peripherals
package comunicaciones_pkg;

  localparam logic [7:0] PAGE_COMUNICACIONES = 8'h9A;

  localparam logic [3:0] REG_RXDATA = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h2;
  localparam logic [3:0] REG_CTRL   = 4'h4;

  localparam int ST_NE      = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_FERR    = 3;
  localparam int ST_PERR    = 4;
  localparam int ST_CNT_LSB = 5;
  localparam int ST_CNT_W   = 5;

  localparam int RXD_VALID  = 8;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/comunicaciones_rx_uart_rx_core.sv
// rtl/comunicaciones_rx_uart_rx_core.sv - rx synchronizer, baud timing and frame FSM (8E1 with COMUNICACIONES_RX_PARITY_EN)
module uart_rx_core
  import comunicaciones_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       byte_stb,
  output logic       ferr_stb,
  output logic       perr_stb
);

  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV) + 1;

  logic          sync1, sync2, prev;
  rx_state_t     state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          par_bad, par_bad_nx;
  logic          fall, bit_end;

  assign fall    = prev & ~sync2;
  assign bit_end = (cnt == CW'(DIV - 1));
  assign data    = shreg;

  // Sync flops reset high so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      prev    <= 1'b1;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      prev    <= sync2;
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      par_bad <= par_bad_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    par_bad_nx = par_bad;
    byte_stb   = 1'b0;
    ferr_stb   = 1'b0;
    perr_stb   = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_nx = '0;
        if (fall) begin
          state_nx   = RX_START;
          bit_idx_nx = '0;
          par_bad_nx = 1'b0;
        end
      end
      RX_START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_nx   = '0;
          state_nx = sync2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          cnt_nx     = '0;
          shreg_nx   = {sync2, shreg[7:1]};
          bit_idx_nx = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef COMUNICACIONES_RX_PARITY_EN
            state_nx = RX_PARITY;
`else
            state_nx = RX_STOP;
`endif
          end
        end
      end
`ifdef COMUNICACIONES_RX_PARITY_EN
      RX_PARITY: begin
        if (bit_end) begin
          cnt_nx   = '0;
          state_nx = RX_STOP;
          if (sync2 != ^shreg) begin
            par_bad_nx = 1'b1;
            perr_stb   = 1'b1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (bit_end) begin
          cnt_nx   = '0;
          state_nx = RX_IDLE;
          if (sync2) byte_stb = ~par_bad;
          else       ferr_stb = 1'b1;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/comunicaciones_rx.sv
// rtl/comunicaciones_rx.sv - Comunicaciones serial receiver with RX FIFO on the J1 I/O bus
// Optional 8E1 framing with COMUNICACIONES_RX_PARITY_EN (handled inside uart_rx_core).
module comunicaciones_rx
  import comunicaciones_pkg::*;
#(
  parameter int clkFreq    = 50000000,
  parameter int baudRate   = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int DIV  = clkFreq / baudRate;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  logic [7:0]      core_data;
  logic            byte_stb, ferr_stb, perr_stb;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CNTW-1:0] count;
  logic            ovr, ferr, perr;
  logic            not_empty, full, pop, push, flush, w1c, ovr_set;
  logic            unused_din;

  uart_rx_core #(.DIV(DIV)) u_core (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (core_data),
    .byte_stb (byte_stb),
    .ferr_stb (ferr_stb),
    .perr_stb (perr_stb)
  );

  assign not_empty = (count != '0);
  assign full      = (count == CNTW'(FIFO_DEPTH));
  assign pop       = cs & rd & (addr == REG_RXDATA) & not_empty;
  assign flush     = cs & wr & (addr == REG_CTRL) & d_in[0];
  assign w1c       = cs & wr & (addr == REG_STATUS);
  // A pop in the same cycle frees the slot for an incoming byte when full.
  assign push      = byte_stb & ~flush & (~full | pop);
  assign ovr_set   = byte_stb & ~flush & full & ~pop;
  assign rx_irq    = not_empty;
  assign unused_din = &{1'b0, d_in[15:5], d_in[1]};

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= core_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CNTW'(push) - CNTW'(pop);
    end
  end

  // Hardware set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      ovr  <= ovr_set  | (ovr  & ~(w1c & d_in[ST_OVR]));
      ferr <= ferr_stb | (ferr & ~(w1c & d_in[ST_FERR]));
      perr <= perr_stb | (perr & ~(w1c & d_in[ST_PERR]));
    end
  end

  always_comb begin
    d_out = '0;
    case (addr)
      REG_RXDATA: begin
        if (not_empty) begin
          d_out[7:0]       = mem[rptr];
          d_out[RXD_VALID] = 1'b1;
        end
      end
      REG_STATUS: begin
        d_out[ST_NE]   = not_empty;
        d_out[ST_FULL] = full;
        d_out[ST_OVR]  = ovr;
        d_out[ST_FERR] = ferr;
        d_out[ST_PERR] = perr;
        d_out[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(count);
      end
      default: d_out = '0;
    endcase
  end

endmodule

// File: tb/tb_comunicaciones_rx.sv
// tb/tb_comunicaciones_rx.sv - directed scoreboard bench for comunicaciones_rx (DIV=10)
// Parity steps are built only when COMUNICACIONES_RX_PARITY_EN is defined.
module tb_comunicaciones_rx;

  localparam int DIV = 10;
`ifdef COMUNICACIONES_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int STOP_CYC = PAR_EN ? 107 : 97;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;
  logic        rx;
  logic        rx_irq;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  comunicaciones_rx #(.clkFreq(1000000), .baudRate(100000), .FIFO_DEPTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .d_in   (d_in),
    .cs     (cs),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .d_out  (d_out),
    .rx     (rx),
    .rx_irq (rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [15:0] v);
    addr = a; cs = 1'b1; rd = 1'b1;
    #1 v = d_out;
    @(posedge clk);
    #1 cs = 1'b0; rd = 1'b0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] v);
    addr = a; d_in = v; cs = 1'b1; wr = 1'b1;
    @(posedge clk);
    #1 cs = 1'b0; wr = 1'b0; d_in = '0;
  endtask

  task automatic check_status(input string tag, input logic [15:0] exp);
    logic [15:0] v;
    bus_read(4'h2, v);
    check(tag, v, exp);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] v;
    logic [7:0]  e;
    bus_read(4'h0, v);
    if (exp_q.size() == 0) begin
      check(tag, v, 16'h0000);
    end else begin
      e = exp_q.pop_front();
      check(tag, v, {7'b0, 1'b1, e});
    end
  endtask

  // Frame: start, 8 data LSB first, optional even parity, stop, one idle bit time.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input logic par_ok);
    logic [10:0] frame;
    frame = {stop_ok, (^b) ^ ~par_ok, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == 9 && !PAR_EN) continue;
      rx = frame[i];
      wait_cycles(DIV);
    end
    rx = 1'b1;
    wait_cycles(DIV);
  endtask

  initial begin
    logic [15:0] v;
    rst = 1'b1; rx = 1'b1; d_in = '0; cs = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0;
    wait_cycles(3);
    rst = 1'b0;
    #1;
    check("reset_dout", d_out, 16'h0000);
    check("reset_irq", {15'b0, rx_irq}, 16'h0000);
    check_status("reset_status", 16'h0000);

    // Single byte
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b1);
    check("a5_irq", {15'b0, rx_irq}, 16'h0001);
    check_status("a5_status", 16'h0021);
    addr = 4'h0; rd = 1'b1; cs = 1'b0;
    wait_cycles(1);
    rd = 1'b0;
    check_status("rd_without_cs", 16'h0021);
    pop_check("a5_rxdata");
    check_status("a5_status_after", 16'h0000);
    check("a5_irq_after", {15'b0, rx_irq}, 16'h0000);

    // Overflow: nine bytes into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1, 1'b1);
    end
    check_status("ovr_status", 16'h0107);
    for (int i = 0; i < 8; i++) pop_check($sformatf("ovr_pop%0d", i));
    check_status("ovr_drained", 16'h0004);
    pop_check("empty_pop");
    bus_write(4'h2, 16'h0004);
    check_status("ovr_w1c", 16'h0000);

    // Framing error, then a good byte, then flush
    send_byte(8'h3C, 1'b0, 1'b1);
    check_status("ferr_status", 16'h0008);
    check("ferr_irq", {15'b0, rx_irq}, 16'h0000);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 1'b1);
    check_status("ferr_next", 16'h0029);
    bus_write(4'h4, 16'h0001);
    exp_q.delete();
    check_status("flush_status", 16'h0008);
    bus_write(4'h2, 16'h0008);
    check_status("ferr_w1c", 16'h0000);

    // Glitch rejection
    rx = 1'b0;
    wait_cycles(3);
    rx = 1'b1;
    wait_cycles(30);
    check_status("glitch_status", 16'h0000);

    // Reset mid-frame, then a clean byte
    rx = 1'b0; wait_cycles(DIV);
    rx = 1'b1; wait_cycles(DIV);
    rx = 1'b0; wait_cycles(5);
    rst = 1'b1; rx = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(20);
    check_status("midrst_status", 16'h0000);
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, 1'b1);
    check_status("7e_status", 16'h0021);
    pop_check("7e_rxdata");
    check_status("7e_empty", 16'h0000);

    // Full FIFO with a pop on the stop-sample cycle of a new byte
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_byte(8'h10 + 8'(i), 1'b1, 1'b1);
    end
    check_status("full_status", 16'h0103);
    exp_q.push_back(8'h18);
    fork
      send_byte(8'h18, 1'b1, 1'b1);
      begin
        repeat (STOP_CYC) @(posedge clk);
        #1;
        addr = 4'h0; cs = 1'b1; rd = 1'b1;
        #1 v = d_out;
        check("simul_pop", v, {7'b0, 1'b1, exp_q.pop_front()});
        @(posedge clk);
        #1 cs = 1'b0; rd = 1'b0;
      end
    join
    check_status("simul_status", 16'h0103);
    for (int i = 0; i < 8; i++) pop_check($sformatf("simul_drain%0d", i));
    check_status("simul_empty", 16'h0000);

`ifdef COMUNICACIONES_RX_PARITY_EN
    send_byte(8'h03, 1'b1, 1'b0);
    check_status("perr_status", 16'h0010);
    bus_write(4'h2, 16'h0010);
    check_status("perr_w1c", 16'h0000);
    exp_q.push_back(8'h03);
    send_byte(8'h03, 1'b1, 1'b1);
    check_status("par_ok_status", 16'h0021);
    pop_check("par_ok_rxdata");
`else
    bus_write(4'h2, 16'h001C);
    check_status("perr_absent", 16'h0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
